// File: rtl/warp_table.sv
`default_nettype none
// ============================================================================
// warp_table : DEPTH x WIDTH FIFO with registered pop data and empty-bypass
// Rev 1.0
// ============================================================================
module warp_table #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read_en,
    input  logic             write_en,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
    input  logic [WIDTH-1:0] write_data,
    output logic             fifo_empty,
    output logic             fifo_vacant,
    output logic             fifo_full
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   c_FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_VACANT_MAX = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0]   c_CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE    = (AW)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] read_data_q, read_data_d;
    logic             read_valid_q, read_valid_d;
    logic             mem_we;

    logic w_empty;
    logic w_full;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_FULL_CNT);

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        mem_we       = 1'b0;

        if (read_en && w_empty) begin
            // Empty bypass: the write goes straight to the output, storage untouched.
            if (write_en) begin
                read_data_d  = write_data;
                read_valid_d = 1'b1;
            end
        end else if (read_en) begin
            read_data_d  = mem_q[rd_ptr_q];
            read_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + c_PTR_ONE;
            if (write_en) begin
                // Slot freed by this pop makes room even when full.
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end else begin
                count_d  = count_q - c_CNT_ONE;
            end
        end else if (write_en && !w_full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            count_d  = count_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    assign read_data   = read_data_q;
    assign read_valid  = read_valid_q;
    assign fifo_empty  = w_empty;
    assign fifo_full   = w_full;
    assign fifo_vacant = (count_q <= c_VACANT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_warp_table.sv
`default_nettype none
// ============================================================================
// tb_warp_table : queue-model checker plus directed vectors for warp_table
// Rev 1.0
// ============================================================================
module tb_warp_table;

    localparam int WIDTH = 44;
    localparam int DEPTH = 32;

    logic             clk;
    logic             rst_n;
    logic             read_en;
    logic             write_en;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic [WIDTH-1:0] write_data;
    logic             fifo_empty;
    logic             fifo_vacant;
    logic             fifo_full;

    int n_vec;
    int n_err;

    warp_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_en    (read_en),
        .write_en   (write_en),
        .read_data  (read_data),
        .read_valid (read_valid),
        .write_data (write_data),
        .fifo_empty (fifo_empty),
        .fifo_vacant(fifo_vacant),
        .fifo_full  (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of live entries plus the expected output register.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_data;
    logic             m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_data  = '0;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (read_en) begin
                if (mq.size() == 0) begin
                    if (write_en) begin
                        m_data  = write_data;
                        m_valid = 1'b1;
                    end
                end else begin
                    m_data  = mq.pop_front();
                    m_valid = 1'b1;
                    if (write_en) mq.push_back(write_data);
                end
            end else if (write_en && mq.size() < DEPTH) begin
                mq.push_back(write_data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid",  {63'd0, read_valid},  {63'd0, m_valid});
            chk("model_data",   {20'd0, read_data},   {20'd0, m_data});
            chk("model_empty",  {63'd0, fifo_empty},  {63'd0, mq.size() == 0});
            chk("model_vacant", {63'd0, fifo_vacant}, {63'd0, mq.size() <= DEPTH - 2});
            chk("model_full",   {63'd0, fifo_full},   {63'd0, mq.size() == DEPTH});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic we, input logic [WIDTH-1:0] wd);
        read_en    = re;
        write_en   = we;
        write_data = wd;
    endtask

    logic [WIDTH-1:0] held;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0);
        #3;
        chk("rst_valid",  {63'd0, read_valid},  64'd0);
        chk("rst_data",   {20'd0, read_data},   64'd0);
        chk("rst_empty",  {63'd0, fifo_empty},  64'd1);
        chk("rst_vacant", {63'd0, fifo_vacant}, 64'd1);
        chk("rst_full",   {63'd0, fifo_full},   64'd0);
        step();
        step();
        rst_n = 1'b1;

        // First edge after reset: empty bypass
        drive(1'b1, 1'b1, 44'h0_1234_5678);
        step();
        chk("bypass_valid", {63'd0, read_valid}, 64'd1);
        chk("bypass_data",  {20'd0, read_data},  64'h0_1234_5678);
        chk("bypass_empty", {63'd0, fifo_empty}, 64'd1);

        // Fill to full, tracking vacant/full thresholds
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, WIDTH'(i));
            step();
            chk("fill_valid",  {63'd0, read_valid},  64'd0);
            chk("fill_vacant", {63'd0, fifo_vacant}, {63'd0, (i + 1) <= 30});
            chk("fill_full",   {63'd0, fifo_full},   {63'd0, (i + 1) == 32});
        end

        // Push while full is dropped
        drive(1'b0, 1'b1, 44'hABC);
        step();
        chk("drop_full",  {63'd0, fifo_full},  64'd1);
        chk("drop_valid", {63'd0, read_valid}, 64'd0);

        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, '0);
            step();
            chk("drain_valid", {63'd0, read_valid}, 64'd1);
            chk("drain_data",  {20'd0, read_data},  64'(i));
        end
        chk("drain_empty", {63'd0, fifo_empty}, 64'd1);

        // Pop while empty: no valid, data holds last value (31)
        drive(1'b1, 1'b0, 44'h555);
        step();
        chk("empty_pop_valid", {63'd0, read_valid}, 64'd0);
        chk("empty_pop_data",  {20'd0, read_data},  64'd31);

        // Move pointers to 30 so the streaming run wraps
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 1'b1, WIDTH'(1000 + i));
            step();
        end
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b0, '0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, WIDTH'(100 + i));
            step();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, WIDTH'(200 + k));
            step();
            chk("stream_valid", {63'd0, read_valid}, 64'd1);
            chk("stream_data",  {20'd0, read_data},  (k < 5) ? 64'(100 + k) : 64'(200 + k - 5));
            chk("stream_empty", {63'd0, fifo_empty}, 64'd0);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, '0);
            step();
            chk("tail_data", {20'd0, read_data}, 64'(205 + k));
        end
        chk("tail_empty", {63'd0, fifo_empty}, 64'd1);

        // Occupancy 7, then asynchronous reset pulse between edges
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, WIDTH'(300 + i));
            step();
        end
        drive(1'b1, 1'b0, '0);
        step();
        chk("pre_rst_data", {20'd0, read_data}, 64'd300);
        drive(1'b0, 1'b0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, read_valid},  64'd0);
        chk("async_rst_data",  {20'd0, read_data},   64'd0);
        chk("async_rst_empty", {63'd0, fifo_empty},  64'd1);
        chk("async_rst_vac",   {63'd0, fifo_vacant}, 64'd1);
        chk("async_rst_full",  {63'd0, fifo_full},   64'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, '0);
        step();
        chk("post_rst_valid", {63'd0, read_valid}, 64'd0);
        chk("post_rst_empty", {63'd0, fifo_empty}, 64'd1);

        drive(1'b0, 1'b0, '0);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/warp_table.md
WARP_TABLE -- requirements
Module: warp_table

Interface
REQ-001 Parameter WIDTH, default 44, bits per entry.
REQ-002 Parameter DEPTH, default 32, number of entries; power of two, at least 4.
REQ-003 Ports SHALL appear in the positional order below.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 read_en  input  1  pop request.
REQ-007 write_en  input  1  push request.
REQ-008 read_data  output  WIDTH  registered pop data.
REQ-009 read_valid  output  1  registered; read_data holds a popped entry this cycle.
REQ-010 write_data  input  WIDTH  push data.
REQ-011 fifo_empty  output  1  occupancy == 0.
REQ-012 fifo_vacant  output  1  occupancy <= DEPTH-2, i.e. at least two free slots.
REQ-013 fifo_full  output  1  occupancy == DEPTH.

Function
REQ-014 The block SHALL be a first-in first-out queue of DEPTH entries with a read pointer, a write pointer and an occupancy counter of width log2(DEPTH)+1.
REQ-015 Pointers SHALL wrap modulo DEPTH.
REQ-016 fifo_empty, fifo_vacant and fifo_full SHALL be decoded combinationally from the registered occupancy.
REQ-017 Push only (write_en=1, read_en=0, not full): on the clock edge, write_data is stored at the write pointer, the write pointer advances and occupancy increments; read_valid=0 next cycle.
REQ-018 Push while full with no read: the push SHALL be dropped and no state SHALL change.
REQ-019 Pop only (read_en=1, write_en=0, not empty): on the clock edge, read_data receives the oldest entry, read_valid=1 next cycle, the read pointer advances and occupancy decrements.
REQ-020 Pop while empty with no write: read_valid=0 next cycle and read_data SHALL hold its previous value.
REQ-021 Bypass (read_en=1, write_en=1, empty): read_data <= write_data and read_valid=1 on the same edge (one-cycle latency); storage, pointers and occupancy SHALL be unchanged and fifo_empty SHALL stay 1.
REQ-022 Simultaneous push and pop, not empty (including full): the oldest entry is popped to read_data with read_valid=1, write_data is stored at the write pointer, both pointers advance, and occupancy is unchanged.
REQ-023 With read_en=0, read_valid SHALL be 0 next cycle and read_data SHALL hold its value.
REQ-024 Read latency SHALL be exactly one clock from the read_en sample edge to valid data.
REQ-025 Data order SHALL be preserved; no entry is duplicated or lost except a push dropped under REQ-018.

Reset
REQ-026 While rst_n=0, immediately and independently of clk, the block SHALL hold: pointers=0, occupancy=0, read_data=0, read_valid=0, fifo_empty=1, fifo_vacant=1, fifo_full=0.
REQ-027 Storage array contents need not be reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries.
REQ-029 The first edge after rst_n rises SHALL operate normally.

Verification
REQ-030 Reset, then the first edge with read_en=1, write_en=1, write_data=44'h0_1234_5678 -> next cycle read_valid=1, read_data=44'h0_1234_5678, fifo_empty=1.
REQ-031 Push 0..DEPTH-1 (32 entries), then read_en=1 for 32 cycles -> fifo_vacant falls at occupancy 31, fifo_full=1 at 32; pops return 0..31 in order with read_valid=1; fifo_empty=1 at the end.
REQ-032 With the block full, push 44'hABC and no read -> dropped; occupancy stays 32; the next 32 pops never return 44'hABC.
REQ-033 Occupancy 5, simultaneous push/pop for 10 cycles -> occupancy stays 5; output order is continuous across pointer wrap.
REQ-034 read_en=1 while empty with write_en=0 -> read_valid=0 and read_data unchanged.
REQ-035 rst_n pulsed low at occupancy 7, between clock edges -> outputs take reset values immediately; the next pop while empty gives read_valid=0.
